// File: rtl/load_port.sv
// Load port: serves single loads from data memory, a synchronized external input
// port, or a status register holding the "new port data" ready flag.
module load_port #(
    parameter logic [7:0] PORT_ADDR = 8'hFF,
    parameter logic [7:0] STAT_ADDR = 8'hFE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       re,
    input  logic [7:0] Address,
    input  logic [7:0] MemData,
    input  logic [7:0] PortIn,
    output logic       rden,
    output logic [7:0] DataOut,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SRC_MEM, SRC_PORT, SRC_STAT} src_t;

    state_t     state_q, state_d;
    src_t       src_q, src_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;
    logic [7:0] sync1_q, port_sync_q, port_prev_q;

    logic       accept;
    logic       change;
    logic       port_capture;

    always_comb begin
        accept       = re && (state_q == IDLE);
        change       = (port_sync_q != port_prev_q);
        port_capture = (state_q == WAIT) && (src_q == SRC_PORT);

        state_d = state_q;
        src_d   = src_q;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (re) begin
                    if (Address == PORT_ADDR)      src_d = SRC_PORT;
                    else if (Address == STAT_ADDR) src_d = SRC_STAT;
                    else                           src_d = SRC_MEM;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                case (src_q)
                    SRC_PORT: data_d = port_sync_q;
                    SRC_STAT: data_d = {7'b0, ready_q};
                    default:  data_d = MemData;
                endcase
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A change seen on the capture edge wins, so a fresh value is never lost.
        ready_d = change || (ready_q && !port_capture);
    end

    // NOTE: every flop below uses <= so all registers update from pre-edge values;
    // the synchronizer chain depends on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= SRC_MEM;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            sync1_q     <= 8'h00;
            port_sync_q <= 8'h00;
            port_prev_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            data_q      <= data_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            sync1_q     <= PortIn;
            port_sync_q <= sync1_q;
            port_prev_q <= port_sync_q;
        end
    end

    assign rden    = accept && !rst && (Address != PORT_ADDR) && (Address != STAT_ADDR);
    assign DataOut = data_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule
